// File: rtl/soh_pipe.sv
// Second-operand former: decodes S into an operand and buffers it in a 2-entry FIFO.
// Tracks illegal selectors with a sticky flag and counts delivered operands.
module soh_pipe #(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] R,
  input  logic [12:0]       imm13,
  input  logic [21:0]       imm22,
  input  logic [29:0]       disp30,
  input  logic [3:0]        S,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] N,
  output logic              out_err,
  output logic              err_seen,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  ops_cnt
);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] n;
  } ent_t;

  ent_t             mem_q [2];
  ent_t             ent_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] ops_q;
  logic             err_seen_q, err_seen_d;
  logic             push, pop;

  // Fill the extension bits first, then overlay the field; avoids zero-width
  // replications when DATA_W equals the field width.
  always_comb begin
    ent_d     = '0;
    ent_d.err = 1'b0;
    unique case (S)
      4'b0000: ent_d.n = R;
      4'b0001: begin
        ent_d.n       = {DATA_W{imm13[12]}};
        ent_d.n[12:0] = imm13;
      end
      4'b0010: ent_d.n[31:0] = {imm22, 10'b0};
      4'b0011: begin
        ent_d.n       = {DATA_W{imm22[21]}};
        ent_d.n[23:0] = {imm22, 2'b00};
      end
      4'b0100: ent_d.n[SH_W-1:0] = R[SH_W-1:0];
      4'b0101: ent_d.n[SH_W-1:0] = imm13[SH_W-1:0];
      4'b0110: begin
        ent_d.n       = {DATA_W{disp30[29]}};
        ent_d.n[31:0] = {disp30, 2'b00};
      end
      4'b0111: ent_d.n[12:0] = imm13;
      default: begin
        ent_d.n   = R;
        ent_d.err = 1'b1;
      end
    endcase
  end

  assign in_ready  = rst_n & (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // An error push in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_seen_d = err_seen_q;
    if (push && ent_d.err) err_seen_d = 1'b1;
    else if (err_clr)      err_seen_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      ops_q      <= '0;
      err_seen_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= ent_d;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        ops_q    <= ops_q + 1'b1;
      end
      cnt_q      <= cnt_d;
      err_seen_q <= err_seen_d;
    end
  end

  assign N        = mem_q[rd_ptr_q].n;
  assign out_err  = mem_q[rd_ptr_q].err;
  assign err_seen = err_seen_q;
  assign ops_cnt  = ops_q;

endmodule

// File: tb/tb_soh_pipe.sv
// Directed bench for soh_pipe: 32-bit (CNT_W=4) and 64-bit instances, scoreboard queues
// filled at push time and drained by a negedge monitor.
module tb_soh_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        iv32 = 1'b0, iv64 = 1'b0, out_ready = 1'b1, err_clr = 1'b0;
  logic [63:0] R = '0;
  logic [12:0] imm13 = '0;
  logic [21:0] imm22 = '0;
  logic [29:0] disp30 = '0;
  logic [3:0]  S = '0;

  logic        rdy32, ov32, oe32, es32;
  logic [31:0] n32;
  logic [3:0]  oc32;
  logic        rdy64, ov64, oe64, es64;
  logic [63:0] n64;
  logic [15:0] oc64;

  int checks = 0, errors = 0, cyc = 0, stalls = 0;
  logic [64:0] q32[$], q64[$];
  logic [64:0] e32, e64;
  int pops32[$];

  soh_pipe #(.DATA_W(32), .CNT_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .R(R[31:0]),
    .imm13(imm13), .imm22(imm22), .disp30(disp30), .S(S), .out_valid(ov32),
    .out_ready(out_ready), .N(n32), .out_err(oe32), .err_seen(es32),
    .err_clr(err_clr), .ops_cnt(oc32));

  soh_pipe #(.DATA_W(64), .CNT_W(16)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(rdy64), .R(R),
    .imm13(imm13), .imm22(imm22), .disp30(disp30), .S(S), .out_valid(ov64),
    .out_ready(out_ready), .N(n64), .out_err(oe64), .err_seen(es64),
    .err_clr(err_clr), .ops_cnt(oc64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // A pop happens at the next posedge whenever out_valid & out_ready hold here.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (ov32 && out_ready) begin
        pops32.push_back(cyc);
        checks++;
        assert (q32.size() != 0) else begin
          errors++;
          $error("FAIL q32_unexpected observed=%0h expected=none", n32);
        end
        if (q32.size() != 0) begin
          e32 = q32.pop_front();
          checks++;
          assert ({oe32, n32} === {e32[64], e32[31:0]}) else begin
            errors++;
            $error("FAIL out32 observed=%0h/%0b expected=%0h/%0b", n32, oe32, e32[31:0], e32[64]);
          end
        end
      end
      if (ov64 && out_ready) begin
        checks++;
        assert (q64.size() != 0) else begin
          errors++;
          $error("FAIL q64_unexpected observed=%0h expected=none", n64);
        end
        if (q64.size() != 0) begin
          e64 = q64.pop_front();
          checks++;
          assert ({oe64, n64} === e64) else begin
            errors++;
            $error("FAIL out64 observed=%0h/%0b expected=%0h/%0b", n64, oe64, e64[63:0], e64[64]);
          end
        end
      end
    end
  end

  task automatic drive(input bit sel, input logic [3:0] s, input logic [63:0] r,
                       input logic [12:0] i13, input logic [21:0] i22, input logic [29:0] d30,
                       input logic [63:0] en, input logic ee);
    bit done = 1'b0;
    @(posedge clk); #1;
    S = s; R = r; imm13 = i13; imm22 = i22; disp30 = d30;
    iv32 = !sel; iv64 = sel;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (sel ? rdy64 : rdy32) begin
        done = 1'b1;
        if (sel) q64.push_back({ee, en});
        else     q32.push_back({ee, en});
      end else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL drive_timeout observed=not_ready expected=accepted");
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    iv32 = 1'b0; iv64 = 1'b0; err_clr = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && (q32.size() != 0 || q64.size() != 0); t++) @(negedge clk);
    chk("drain_q32", 64'(q32.size()), 64'd0);
    chk("drain_q64", 64'(q64.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    iv32 = 1'b0; iv64 = 1'b0;
    q32.delete(); q64.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rdy32", 64'(rdy32), 64'd0);
    chk("rst_ov32",  64'(ov32),  64'd0);
    chk("rst_n32",   64'(n32),   64'd0);
    chk("rst_oe32",  64'(oe32),  64'd0);
    chk("rst_es32",  64'(es32),  64'd0);
    chk("rst_oc32",  64'(oc32),  64'd0);
    chk("rst_rdy64", 64'(rdy64), 64'd0);
    chk("rst_ov64",  64'(ov64),  64'd0);
    chk("rst_n64",   n64,        64'd0);
    chk("rst_oc64",  64'(oc64),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy32", 64'(rdy32), 64'd1);

    // 32-bit mode sweep
    drive(0, 4'b0001, 64'h0, 13'h1FFF, 22'h0, 30'h0, 64'hFFFFFFFF, 1'b0);
    drive(0, 4'b0010, 64'h0, 13'h0, 22'h3FFFFF, 30'h0, 64'hFFFFFC00, 1'b0);
    drive(0, 4'b0011, 64'h0, 13'h0, 22'h200000, 30'h0, 64'hFF800000, 1'b0);
    drive(0, 4'b0110, 64'h0, 13'h0, 22'h0, 30'h20000000, 64'h80000000, 1'b0);
    drive(0, 4'b0101, 64'h0, 13'h0FFF, 22'h0, 30'h0, 64'h1F, 1'b0);
    drive(0, 4'b0000, 64'hDEADBEEF, 13'h0, 22'h0, 30'h0, 64'hDEADBEEF, 1'b0);
    drive(0, 4'b0100, 64'h1234567F, 13'h0, 22'h0, 30'h0, 64'h1F, 1'b0);
    drive(0, 4'b0111, 64'h0, 13'h1FFF, 22'h0, 30'h0, 64'h1FFF, 1'b0);
    idle();
    drain();
    chk("sweep_ops32", 64'(oc32), 64'd8);

    // 64-bit modes
    drive(1, 4'b0010, 64'h0, 13'h0, 22'h3FFFFF, 30'h0, 64'h00000000FFFFFC00, 1'b0);
    drive(1, 4'b0100, 64'hFF, 13'h0, 22'h0, 30'h0, 64'h3F, 1'b0);
    drive(1, 4'b0001, 64'h0, 13'h1000, 22'h0, 30'h0, 64'hFFFFFFFFFFFFF000, 1'b0);
    drive(1, 4'b0110, 64'h0, 13'h0, 22'h0, 30'h20000000, 64'hFFFFFFFF80000000, 1'b0);
    drive(1, 4'b0011, 64'h0, 13'h0, 22'h1FFFFF, 30'h0, 64'h00000000007FFFFC, 1'b0);
    idle();
    drain();
    chk("sweep_ops64", 64'(oc64), 64'd5);

    // illegal selector and sticky flag
    chk("es32_clean", 64'(es32), 64'd0);
    drive(0, 4'b1010, 64'h1234, 13'h0, 22'h0, 30'h0, 64'h1234, 1'b1);
    idle();
    @(negedge clk);
    chk("es32_set", 64'(es32), 64'd1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("es32_cleared", 64'(es32), 64'd0);
    err_clr = 1'b1;
    drive(0, 4'b1111, 64'h55, 13'h0, 22'h0, 30'h0, 64'h55, 1'b1);
    idle();
    @(negedge clk);
    chk("es32_clr_vs_err", 64'(es32), 64'd1);
    drain();

    // backpressure
    do_reset();
    out_ready = 1'b0;
    drive(0, 4'b0000, 64'hA5A5A5A5, 13'h0, 22'h0, 30'h0, 64'hA5A5A5A5, 1'b0);
    drive(0, 4'b0111, 64'h0, 13'h0ABC, 22'h0, 30'h0, 64'h0ABC, 1'b0);
    idle();
    @(negedge clk);
    chk("bp_rdy", 64'(rdy32), 64'd0);
    chk("bp_ov",  64'(ov32),  64'd1);
    chk("bp_n",   64'(n32),   64'hA5A5A5A5);
    R = 64'h0; S = 4'b1111; imm13 = 13'h1FFF;
    repeat (3) @(negedge clk);
    chk("bp_n_stable", 64'(n32), 64'hA5A5A5A5);
    chk("bp_err_stable", 64'(oe32), 64'd0);
    pops32.delete();
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    chk("bp_pops", 64'(pops32.size()), 64'd2);
    if (pops32.size() == 2) chk("bp_consec", 64'(pops32[1] - pops32[0]), 64'd1);
    chk("bp_ops", 64'(oc32), 64'd2);

    // push+pop at count 1
    pops32.delete();
    stalls = 0;
    for (int i = 1; i <= 3; i++)
      drive(0, 4'b0000, 64'(i), 13'h0, 22'h0, 30'h0, 64'(i), 1'b0);
    idle();
    drain();
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_pops", 64'(pops32.size()), 64'd3);
    if (pops32.size() == 3) chk("stream_b2b", 64'(pops32[2] - pops32[0]), 64'd2);

    // counter wrap
    do_reset();
    for (int i = 0; i < 17; i++)
      drive(0, 4'b0000, 64'(i + 16), 13'h0, 22'h0, 30'h0, 64'(i + 16), 1'b0);
    idle();
    drain();
    chk("wrap_ops", 64'(oc32), 64'd1);

    // asynchronous reset with two entries buffered
    out_ready = 1'b0;
    drive(0, 4'b0000, 64'h77, 13'h0, 22'h0, 30'h0, 64'h77, 1'b0);
    drive(0, 4'b0000, 64'h88, 13'h0, 22'h0, 30'h0, 64'h88, 1'b0);
    idle();
    @(negedge clk);
    chk("mid_full", 64'(rdy32), 64'd0);
    chk("mid_ops_pre", 64'(oc32), 64'd1);
    #2 rst_n = 1'b0;
    q32.delete();
    #1;
    chk("mid_ov",  64'(ov32),  64'd0);
    chk("mid_ops", 64'(oc32),  64'd0);
    chk("mid_rdy", 64'(rdy32), 64'd0);
    chk("mid_n",   64'(n32),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_post_ov", 64'(ov32), 64'd0);
    drive(0, 4'b0000, 64'h99, 13'h0, 22'h0, 30'h0, 64'h99, 1'b0);
    idle();
    drain();
    chk("mid_post_ops", 64'(oc32), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
